// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared definitions for the pulse_gen register-mapped
// pulse-train generator: register offsets inside the decoded window,
// CTRL bit positions and the FSM state type.
package pulse_gen_pkg;

    localparam logic [2:0] CTRL_OFS     = 3'd0;
    localparam logic [2:0] STATUS_OFS   = 3'd1;
    localparam logic [2:0] PERIOD_L_OFS = 3'd2;
    localparam logic [2:0] PERIOD_H_OFS = 3'd3;
    localparam logic [2:0] WIDTH_L_OFS  = 3'd4;
    localparam logic [2:0] WIDTH_H_OFS  = 3'd5;
    localparam logic [2:0] COUNT_OFS    = 3'd6;
    localparam logic [2:0] EMITTED_OFS  = 3'd7;

    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_STOP_BIT     = 1;
    localparam int CTRL_CONT_BIT     = 2;
    localparam int CTRL_SOFT_RST_BIT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_gen_timer.sv
// pulse_gen_timer: 16-bit loadable down-counter shared by the HIGH and LOW
// phases of pulse_gen. Holds at zero once it gets there.
//   clk      : system clock
//   res      : synchronous active-high reset (counter -> 0)
//   load     : load load_val on this edge (has priority over en)
//   load_val : value to load
//   en       : decrement by one when non-zero
//   zero     : counter is zero (phase ends on this cycle)
module pulse_gen_timer (
    input  logic        clk,
    input  logic        res,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    output logic        zero
);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (res) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != 16'd0)) begin
            cnt <= cnt - 16'd1;
        end
    end

    assign zero = (cnt == 16'd0);

endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: register-mapped pulse-train generator. Firmware programs
// PERIOD/WIDTH/COUNT over the register bus and writes START; the block then
// emits a finite burst or a continuous train on gen_out.
//   clk      : system clock
//   res      : synchronous active-high reset
//   addr     : register address (window BASE_ADDR .. BASE_ADDR+7)
//   data_in  : write data
//   we       : write strobe
//   data_out : registered read data (0 outside the window)
//   gen_out  : pulse train
//   trig_out : one-cycle marker on the first high cycle of each pulse
//   busy     : FSM not in IDLE
//
// state | meaning
// IDLE  | no train, gen_out low, waiting for a valid START
// HIGH  | gen_out high, timer counts the WIDTH cycles
// LOW   | gen_out low, timer counts the PERIOD-WIDTH cycles
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 'h30
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  gen_out,
    output logic                  trig_out,
    output logic                  busy
);

    // Address decode. The subtraction wraps, so anything below BASE_ADDR
    // lands far above 7 and is rejected by the same compare.
    logic [DATA_WIDTH-1:0] ofs;
    logic                  in_range;
    logic [2:0]            reg_sel;
    logic [7:0]            wdata;

    assign ofs      = addr - BASE_ADDR;
    assign in_range = (ofs < DATA_WIDTH'(8));
    assign reg_sel  = ofs[2:0];
    assign wdata    = data_in[7:0];

    logic ctrl_wr, start_req, stop_req, soft_rst, rst_all;

    assign ctrl_wr   = we && in_range && (reg_sel == CTRL_OFS);
    assign start_req = ctrl_wr && wdata[CTRL_START_BIT];
    assign stop_req  = ctrl_wr && wdata[CTRL_STOP_BIT];
    assign soft_rst  = ctrl_wr && wdata[CTRL_SOFT_RST_BIT];
    assign rst_all   = res || soft_rst;

    // Programmed registers
    logic        cont;
    logic [15:0] period;
    logic [15:0] width;
    logic [7:0]  count;

    // Shadow copies used by a running train
    logic        sh_cont;
    logic [15:0] sh_period;
    logic [15:0] sh_width;
    logic [7:0]  sh_count;

    logic        done;
    logic        cfg_err;
    logic [7:0]  emitted;
    logic [7:0]  emitted_inc;
    logic        trig_q;

    assign emitted_inc = emitted + 8'd1;

    // CONT is taken from the write carrying START, so firmware can select
    // the mode and start in one access.
    logic cfg_ok;
    assign cfg_ok = (period >= 16'd2) && (width != 16'd0) && (width < period)
                    && ((count != 8'd0) || wdata[CTRL_CONT_BIT]);

    state_t state, state_next;

    logic        tmr_load;
    logic [15:0] tmr_val;
    logic        tmr_en;
    logic        tmr_zero;
    logic        start_accept;
    logic        start_reject;
    logic        end_of_pulse;
    logic        burst_done;

    pulse_gen_timer u_timer (
        .clk      (clk),
        .res      (rst_all),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst_all) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Timer is loaded with (cycles - 1) so the phase ends on the cycle where
    // it reads zero; this gives exact WIDTH / PERIOD-WIDTH phase lengths.
    always_comb begin
        state_next   = state;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        tmr_en       = 1'b0;
        start_accept = 1'b0;
        start_reject = 1'b0;
        end_of_pulse = 1'b0;
        burst_done   = 1'b0;
        case (state)
            IDLE: begin
                if (start_req && !stop_req) begin
                    if (cfg_ok) begin
                        start_accept = 1'b1;
                        state_next   = HIGH;
                        tmr_load     = 1'b1;
                        tmr_val      = width - 16'd1;
                    end else begin
                        start_reject = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (stop_req) begin
                    state_next = IDLE;
                end else if (tmr_zero) begin
                    state_next = LOW;
                    tmr_load   = 1'b1;
                    tmr_val    = sh_period - sh_width - 16'd1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            LOW: begin
                if (stop_req) begin
                    state_next = IDLE;
                end else if (tmr_zero) begin
                    end_of_pulse = 1'b1;
                    if (!sh_cont && (emitted_inc == sh_count)) begin
                        burst_done = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = HIGH;
                        tmr_load   = 1'b1;
                        tmr_val    = sh_width - 16'd1;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    logic [7:0] rd_val;

    always_comb begin
        rd_val = 8'h00;
        if (in_range) begin
            case (reg_sel)
                CTRL_OFS:     rd_val = {5'b0, cont, 2'b00};
                STATUS_OFS:   rd_val = {5'b0, cfg_err, done, (state != IDLE)};
                PERIOD_L_OFS: rd_val = period[7:0];
                PERIOD_H_OFS: rd_val = period[15:8];
                WIDTH_L_OFS:  rd_val = width[7:0];
                WIDTH_H_OFS:  rd_val = width[15:8];
                COUNT_OFS:    rd_val = count;
                EMITTED_OFS:  rd_val = emitted;
                default:      rd_val = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_all) begin
            cont      <= 1'b0;
            period    <= '0;
            width     <= '0;
            count     <= '0;
            sh_cont   <= 1'b0;
            sh_period <= '0;
            sh_width  <= '0;
            sh_count  <= '0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            emitted   <= '0;
            trig_q    <= 1'b0;
            data_out  <= '0;
        end else begin
            if (we && in_range) begin
                case (reg_sel)
                    CTRL_OFS:     cont          <= wdata[CTRL_CONT_BIT];
                    PERIOD_L_OFS: period[7:0]   <= wdata;
                    PERIOD_H_OFS: period[15:8]  <= wdata;
                    WIDTH_L_OFS:  width[7:0]    <= wdata;
                    WIDTH_H_OFS:  width[15:8]   <= wdata;
                    COUNT_OFS:    count         <= wdata;
                    default: ;
                endcase
            end
            if (start_accept) begin
                sh_cont   <= wdata[CTRL_CONT_BIT];
                sh_period <= period;
                sh_width  <= width;
                sh_count  <= count;
                done      <= 1'b0;
                cfg_err   <= 1'b0;
                emitted   <= '0;
            end else begin
                if (burst_done) begin
                    done <= 1'b1;
                end
                if (start_reject) begin
                    cfg_err <= 1'b1;
                end
                if (end_of_pulse) begin
                    emitted <= emitted_inc;
                end
            end
            // Marks the first cycle of every HIGH phase.
            trig_q   <= (state_next == HIGH) && (state != HIGH);
            data_out <= DATA_WIDTH'(rd_val);
        end
    end

    assign gen_out  = (state == HIGH);
    assign trig_out = trig_q;
    assign busy     = (state != IDLE);

endmodule
